mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 142 ++++++++++++++
 tb/tb_mem_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage: MEM pipeline stage with a request/acknowledge data-memory port,
// a bounded wait for the acknowledge, and the MEM/WB pipeline register.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   RegWr_EX, MemWr_EX, MemRd_EX  EX/MEM control bits
//   WBdata_EX[1:0]                write-back select: 00 ALU, 01 mem, 10 npc, 11 = 00
//   ALUout, D, npc3 [31:0]        ALU result / data address, store data, return PC
//   rd3[3:0]                      EX/MEM destination register
//   dmem_req, dmem_we             registered memory request and write enable
//   dmem_addr, dmem_wdata [31:0]  registered memory address and store data
//   dmem_rdata[31:0], dmem_ack    memory response
//   stall_mem                     combinational hold for IF/ID/EX and EX/MEM
//   RegWr_MEM, rd4[3:0], wb_data  MEM/WB register contents
//   mem_err                       sticky timeout flag, cleared only by reset
//   fsm_state                     debug view of the FSM (0 = IDLE, 1 = ACCESS)
//
// Memory handshake: once dmem_req rises it stays high, together with dmem_we,
// dmem_addr and dmem_wdata, until the edge at which dmem_ack is sampled high or
// the wait budget runs out. dmem_ack outside an access is ignored.
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWr_EX,
    input  logic        MemWr_EX,
    input  logic        MemRd_EX,
    input  logic [1:0]  WBdata_EX,
    input  logic [31:0] ALUout,
    input  logic [31:0] D,
    input  logic [31:0] npc3,
    input  logic [3:0]  rd3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_mem,
    output logic        RegWr_MEM,
    output logic [3:0]  rd4,
    output logic [31:0] wb_data,
    output logic        mem_err,
    output logic        fsm_state
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] count;
    logic          memop;
    logic          timeout;
    logic [31:0]   wb_sel;

    // A store wins when both MemRd and MemWr are set: dmem_we follows MemWr.
    assign memop     = MemRd_EX | MemWr_EX;
    assign timeout   = (count == CW'(TIMEOUT_CYCLES - 1));
    assign fsm_state = state[0];

    // The ACCESS term is gated by rst_n so a reset cycle never holds the pipe
    // just because the stage was mid-access when reset arrived.
    assign stall_mem = ((state == IDLE) & memop) |
                       (rst_n & (state == ACCESS) & ~dmem_ack & ~timeout);

    // Reserved select 11 falls back to the ALU result.
    always_comb begin
        wb_sel = ALUout;
        case (WBdata_EX)
            2'b01:   wb_sel = dmem_rdata;
            2'b10:   wb_sel = npc3;
            default: wb_sel = ALUout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            RegWr_MEM  <= 1'b0;
            rd4        <= '0;
            wb_data    <= '0;
            mem_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop) begin
                        state      <= ACCESS;
                        count      <= '0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWr_EX;
                        dmem_addr  <= ALUout;
                        dmem_wdata <= D;
                        // stalled cycle: bubble into MEM/WB
                        RegWr_MEM  <= 1'b0;
                        rd4        <= '0;
                        wb_data    <= '0;
                    end else begin
                        RegWr_MEM <= RegWr_EX;
                        rd4       <= rd3;
                        wb_data   <= wb_sel;
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        // ack has priority over a coincident timeout
                        state     <= IDLE;
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        RegWr_MEM <= RegWr_EX;
                        rd4       <= rd3;
                        wb_data   <= wb_sel;
                    end else if (timeout) begin
                        state     <= IDLE;
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        mem_err   <= 1'b1;
                        RegWr_MEM <= 1'b0;
                        rd4       <= '0;
                        wb_data   <= '0;
                    end else begin
                        count     <= count + CW'(1);
                        RegWr_MEM <= 1'b0;
                        rd4       <= '0;
                        wb_data   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage: self-checking bench for mem_stage (TIMEOUT_CYCLES = 4).
// Each operation pushes its expected MEM/WB result {RegWr, rd, wb_data, mem_err}
// into exp_q when driven; the entry is popped and compared once the stage
// releases stall_mem and the result is registered. A small memory responder
// inside the driver raises dmem_ack on a chosen ACCESS cycle.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    localparam int T = 4;
    localparam int W = 38;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWr_EX, MemWr_EX, MemRd_EX;
    logic [1:0]  WBdata_EX;
    logic [31:0] ALUout, D, npc3;
    logic [3:0]  rd3;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stall_mem;
    logic        RegWr_MEM;
    logic [3:0]  rd4;
    logic [31:0] wb_data;
    logic        mem_err;
    logic        fsm_state;

    int          n_vec = 0;
    int          n_err = 0;
    logic [W-1:0] exp_q[$];
    logic        exp_err = 1'b0;

    // clock / reset
    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWr_EX(RegWr_EX), .MemWr_EX(MemWr_EX), .MemRd_EX(MemRd_EX),
        .WBdata_EX(WBdata_EX), .ALUout(ALUout), .D(D), .npc3(npc3), .rd3(rd3),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall_mem(stall_mem), .RegWr_MEM(RegWr_MEM), .rd4(rd4),
        .wb_data(wb_data), .mem_err(mem_err), .fsm_state(fsm_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_ex();
        RegWr_EX = 0; MemWr_EX = 0; MemRd_EX = 0; WBdata_EX = 2'b00;
        ALUout = 0; D = 0; npc3 = 0; rd3 = 0; dmem_ack = 0; dmem_rdata = 0;
    endtask

    // Driver: called on a falling edge; returns on the next falling edge after
    // the result has been checked. ack_at = ACCESS cycle (1-based) that sees
    // dmem_ack; > T means no ack. For non-memory ops, ack_at != 0 raises a stray
    // ack in IDLE.
    task automatic run_op(input logic rw, input logic mw, input logic mr,
                          input logic [1:0] sel, input logic [31:0] alu,
                          input logic [31:0] d, input logic [31:0] npc,
                          input logic [31:0] rdata, input logic [3:0] rd,
                          input int ack_at);
        logic         memop;
        bit           to;
        bit           done;
        int           exp_stalls, acc, stalls, reqs;
        logic [31:0]  wb;
        logic [W-1:0] e;
        memop = mw | mr;
        to = memop && (ack_at > T);
        exp_stalls = !memop ? 0 : (to ? T : ack_at);
        wb = (sel == 2'b01) ? rdata : (sel == 2'b10) ? npc : alu;
        if (to) begin
            exp_err = 1'b1;
            e = {1'b0, 4'd0, 32'd0, 1'b1};
        end else begin
            e = {rw, rd, wb, exp_err};
        end
        exp_q.push_back(e);

        RegWr_EX = rw; MemWr_EX = mw; MemRd_EX = mr; WBdata_EX = sel;
        ALUout = alu; D = d; npc3 = npc; rd3 = rd; dmem_rdata = rdata;
        acc = 0; stalls = 0; reqs = 0; done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (dmem_req) begin
                acc++; reqs++;
                check("acc_we", dmem_we, mw);
                check("acc_addr", dmem_addr, alu);
                check("acc_wdata", dmem_wdata, d);
                check("acc_state", fsm_state, 1'b1);
            end
            dmem_ack = memop ? (acc == ack_at) : (ack_at != 0);
            #1;
            if (stall_mem) stalls++;
            else done = 1;
            @(posedge clk); #1;
            if (!done) begin
                check("bubble", RegWr_MEM, 1'b0);
                @(negedge clk);
            end
        end
        if (!done) check("op_bound", 1'b0, 1'b1);
        check("memwb", {RegWr_MEM, rd4, wb_data, mem_err}, exp_q.pop_front());
        check("stalls", stalls, exp_stalls);
        check("req_cycles", reqs, exp_stalls);
        check("req_drop", {dmem_req, dmem_we, fsm_state}, 3'b000);
        @(negedge clk);
        clear_ex();
    endtask

    initial begin
        int kind, ackv;
        rst_n = 1'b0;
        clear_ex();
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, 66'd0);
        check("rst_memwb", {RegWr_MEM, rd4, wb_data, mem_err, fsm_state}, 39'd0);
        @(negedge clk);
        check("rst_stall", stall_mem, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU op
        run_op(1, 0, 0, 2'b00, 32'h12, 32'h0, 32'h0, 32'h0, 4'd5, 0);
        // load, ack on third ACCESS cycle
        run_op(1, 0, 1, 2'b01, 32'h40, 32'h0, 32'h0, 32'hDEADBEEF, 4'd3, 3);
        // store, immediate ack
        run_op(0, 1, 0, 2'b00, 32'h80, 32'hA5A5A5A5, 32'h0, 32'h0, 4'd0, 1);
        // both bits set behaves as a store
        run_op(1, 1, 1, 2'b10, 32'h84, 32'h5A5A0000, 32'h1234, 32'h0, 4'd9, 2);
        // ack coincides with the timeout cycle
        run_op(1, 0, 1, 2'b01, 32'h44, 32'h0, 32'h0, 32'hCAFEF00D, 4'd7, T);
        // stray ack in IDLE, reserved select 11
        run_op(1, 0, 0, 2'b11, 32'h77, 32'h0, 32'h99, 32'h55, 4'd2, 1);
        // load with no ack: timeout
        run_op(1, 0, 1, 2'b01, 32'h48, 32'h0, 32'h0, 32'h11111111, 4'd4, T + 1);

        // random mix; mem_err must stay sticky from here on
        for (int i = 0; i < 20; i++) begin
            kind = $urandom_range(0, 3);
            ackv = (kind == 0) ? $urandom_range(0, 1) : $urandom_range(1, T + 1);
            run_op(1'($urandom_range(0, 1)), kind[1], kind[0],
                   2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                   $urandom, 4'($urandom_range(0, 15)), ackv);
        end

        // reset in the middle of an access, late ack ignored
        RegWr_EX = 1; MemRd_EX = 1; WBdata_EX = 2'b01; ALUout = 32'h60; rd3 = 4'd6;
        repeat (2) @(negedge clk);
        check("mid_req", dmem_req, 1'b1);
        rst_n = 1'b0;
        clear_ex();
        #1;
        check("mid_rst_stall", stall_mem, 1'b0);
        @(posedge clk); #1;
        check("mid_rst_req", {dmem_req, fsm_state}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hBADBAD00;
        #1;
        check("late_ack_stall", stall_mem, 1'b0);
        @(posedge clk); #1;
        check("late_ack_out", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, 66'd0);
        check("late_ack_memwb", {RegWr_MEM, rd4, wb_data, mem_err, fsm_state}, 39'd0);
        @(negedge clk);
        dmem_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
